pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Stall/flush scheduler for the 5-stage RISC-V pipeline (F/D/E/M/W). It sits beside the
//  forwarding logic and sequences the pipeline registers for four cases:
//  - load-use hazards
//  - taken-branch redirects
//  - multi-cycle mul/div ops in E
//  - data-memory wait states in M
//  It also keeps saturating stall/flush perf counters and a mul/div watchdog flag.
// PARAMETERS
//  CNT_W       32   width of perf counters stall_cnt, flush_cnt
//  MD_TIMEOUT  64   cycles in MD_WAIT before md_timeout sets (sticky)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  MemReadE    in   1   instruction in E is a load
//  RD_E        in   5   destination register of the E instruction
//  RS1_D/RS2_D in   5   source registers of the D instruction
//  PCSrcE      in   1   taken branch/jump resolved in E
//  MdStartE    in   1   E holds a mul/div op (level; held while E is stalled)
//  MdDoneE     in   1   mul/div result valid (1-cycle pulse)
//  DmemReqM    in   1   M instruction accesses data memory
//  DmemReadyM  in   1   data memory completes the access this cycle
//  StallF/D/E/M out 1   hold the PC / IF-ID / ID-EX / EX-MEM register
//  FlushD/E/M/W out 1   clear IF-ID / ID-EX / EX-MEM / MEM-WB to a bubble
//  stall_cnt   out  CNT_W  cycles with StallF=1, saturating
//  flush_cnt   out  CNT_W  cycles with FlushD|FlushE, saturating
//  md_timeout  out  1   sticky watchdog flag
// BEHAVIOUR
//  Reset (rst=1, async):
//  - state=RUN, counters=0, md_timeout=0, md_done_q=0
//  - all Stall*=0, all Flush*=1 while rst is high
//  Hazard terms:
//  - mem_wait = DmemReqM & ~DmemReadyM
//  - lu = MemReadE & RD_E!=0 & (RD_E==RS1_D | RD_E==RS2_D)
//  FSM states: RUN, MD_WAIT, MEM_WAIT. Outputs are combinational from state and inputs,
//   with priority mem_wait > MD_WAIT > PCSrcE > lu.
//  RUN:
//  - mem_wait: StallF/D/E/M=1, FlushW=1; go to MEM_WAIT.
//  - else MdStartE: StallF/D/E=1, FlushM=1; go to MD_WAIT; clear watchdog count.
//  - else PCSrcE: FlushD=1, FlushE=1, no stall. A simultaneous lu is ignored
//    (the D instruction is wrong-path).
//  - else lu: StallF=1, StallD=1, FlushE=1 for exactly one cycle. Next cycle the
//    load is in M, so lu=0 and forwarding from W covers the value.
//  MEM_WAIT: StallF/D/E/M=1, FlushW=1 each cycle with mem_wait. On DmemReadyM=1
//    that cycle is a RUN cycle with no stall, and the FSM returns to RUN.
//    PCSrcE/MdStartE are held by the stalled E register and act in the following RUN cycle.
//  MD_WAIT: StallF/D/E=1 every cycle.
//  - md_done_q sets on MdDoneE.
//  - mem_wait in this state: add StallM=1 and FlushW=1 instead of FlushM=1.
//  - Exit to RUN when (MdDoneE|md_done_q) & ~mem_wait. The exit cycle has no stalls,
//    FlushM=0, and clears md_done_q.
//  - Re-entry guard: in the first RUN cycle after MD exit, MdStartE from the
//    same E instruction must not re-enter MD_WAIT. Use a 1-cycle md_exit_q mask.
//  Watchdog: count cycles in MD_WAIT; when the count reaches MD_TIMEOUT, md_timeout=1 until rst.
//    The FSM stays in MD_WAIT (no forced exit).
//  Counters: +1 per qualifying cycle, hold at 2^CNT_W-1, never wrap.
//  PCSrcE never flushes while StallE=1; the flush fires once E advances.
// STRUCTURE
//  - pipe_ctrl_pkg: typedef enum logic [1:0] {RUN, MD_WAIT, MEM_WAIT} pctl_state_t.
//  - Sub-module sat_counter #(W) (clk, rst, inc, q): instantiated for stall_cnt and flush_cnt.
// TESTING
//  1 lw x5 in E, add x6,x5,x1 in D -> StallF=StallD=FlushE=1 for one cycle; stall_cnt=1.
//  2 lu with RD_E=0 -> no stall, no flush.
//  3 lu and PCSrcE in the same cycle -> FlushD=FlushE=1, StallF=0; flush_cnt=1.
//  4 DmemReqM=1, ready low 3 cycles -> StallF/D/E/M=1 and FlushW=1 for 3 cycles;
//    the 4th cycle is clear; stall_cnt=3.
//  5 MdStartE, MdDoneE after 5 cycles, with mem_wait cycles 3-6 -> StallM only in
//    cycles 3-6; exit after mem_wait clears; no re-entry into MD_WAIT.
//  6 MdStartE, no done, MD_TIMEOUT=4 -> md_timeout=1 after 4 MD cycles; a mid-wait
//    async rst gives RUN, all flushes=1, md_timeout=0 immediately.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush scheduler.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MD_WAIT, MEM_WAIT} pctl_state_t;
endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that pins at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  q <= '0;
    else if (inc && q != '1)  q <= q + W'(1);
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, branch redirect,
// multi-cycle mul/div in E and data-memory wait states in M.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReadE,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic             PCSrcE,
  input  logic             MdStartE,
  input  logic             MdDoneE,
  input  logic             DmemReqM,
  input  logic             DmemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             md_timeout
);
  localparam int WD_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MD_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

  pctl_state_t     state, st_nxt;
  logic            md_done_q, md_exit_q;
  logic [WD_W-1:0] wd_cnt;
  logic            mem_wait, lu, md_enter, md_exit;
  logic [3:0]      stl, fls;  // stl = {F,D,E,M}, fls = {D,E,M,W}

  assign mem_wait = DmemReqM & ~DmemReadyM;
  assign lu = MemReadE & (RD_E != 5'd0) & ((RD_E == RS1_D) | (RD_E == RS2_D));

  always_comb begin
    st_nxt   = state;
    stl      = 4'b0000;
    fls      = 4'b0000;
    md_enter = 1'b0;
    md_exit  = 1'b0;
    unique case (state)
      MD_WAIT: begin
        if ((MdDoneE | md_done_q) & ~mem_wait) begin
          st_nxt  = RUN;
          md_exit = 1'b1;
        end else if (mem_wait) begin
          stl = 4'b1111;
          fls = 4'b0001;
        end else begin
          stl = 4'b1110;
          fls = 4'b0010;
        end
      end
      default: begin
        // MEM_WAIT behaves as a RUN cycle once the memory access completes
        if (mem_wait) begin
          stl    = 4'b1111;
          fls    = 4'b0001;
          st_nxt = MEM_WAIT;
        end else if (MdStartE & ~md_exit_q) begin
          stl      = 4'b1110;
          fls      = 4'b0010;
          st_nxt   = MD_WAIT;
          md_enter = 1'b1;
        end else begin
          st_nxt = RUN;
          if (PCSrcE)  fls = 4'b1100;
          else if (lu) begin
            stl = 4'b1100;
            fls = 4'b0100;
          end
        end
      end
    endcase
  end

  assign {StallF, StallD, StallE, StallM} = stl & {4{~rst}};
  assign {FlushD, FlushE, FlushM, FlushW} = fls | {4{rst}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      md_done_q  <= 1'b0;
      md_exit_q  <= 1'b0;
      wd_cnt     <= '0;
      md_timeout <= 1'b0;
    end else begin
      state     <= st_nxt;
      md_exit_q <= md_exit;
      if (md_exit)                           md_done_q <= 1'b0;
      else if (state == MD_WAIT && MdDoneE)  md_done_q <= 1'b1;
      if (md_enter)                                  wd_cnt <= '0;
      else if (state == MD_WAIT && wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WD_W'(1);
      // the watchdog only flags; the FSM keeps waiting for MdDoneE
      if (state == MD_WAIT && wd_cnt >= WD_LAST)     md_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(StallF), .q(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(FlushD | FlushE), .q(flush_cnt)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with narrow counters and a short watchdog.
module tb_pipeline_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       MemReadE, PCSrcE, MdStartE, MdDoneE, DmemReqM, DmemReadyM;
  logic [4:0] RD_E, RS1_D, RS2_D;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [3:0] stall_cnt, flush_cnt;
  logic       md_timeout;
  logic [7:0] ctl;
  int total = 0;
  int bad = 0;

  pipeline_ctrl #(.CNT_W(4), .MD_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .MemReadE(MemReadE), .RD_E(RD_E), .RS1_D(RS1_D), .RS2_D(RS2_D),
    .PCSrcE(PCSrcE), .MdStartE(MdStartE), .MdDoneE(MdDoneE),
    .DmemReqM(DmemReqM), .DmemReadyM(DmemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .md_timeout(md_timeout)
  );

  always #5 clk = ~clk;
  // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushM,FlushW}
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic pc, input logic ms,
                       input logic md, input logic dq, input logic dr);
    MemReadE = mr; RD_E = rd; RS1_D = rs1; RS2_D = rs2; PCSrcE = pc;
    MdStartE = ms; MdDoneE = md; DmemReqM = dq; DmemReadyM = dr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1, 5, 5, 0, 1, 1, 0, 1, 0);
    #1;
    total++; if (ctl !== 8'b0000_1111) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 8'b0000_1111); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    total++; if (flush_cnt !== 4'd0) begin bad++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt); end
    total++; if (md_timeout !== 1'b0) begin bad++; $display("FAIL reset_md_timeout got=%b exp=0", md_timeout); end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (ctl !== 8'b0) begin bad++; $display("FAIL idle_ctl got=%b exp=%b", ctl, 8'b0); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 5, 5, 1, 0, 0, 0, 0, 0);
    #1;
    total++; if (ctl !== 8'b1100_0100) begin bad++; $display("FAIL lu_rs1_ctl got=%b exp=%b", ctl, 8'b1100_0100); end
    @(negedge clk);
    drive(0, 0, 5, 1, 0, 0, 0, 0, 0);
    #1;
    total++; if (ctl !== 8'b0) begin bad++; $display("FAIL lu_after_ctl got=%b exp=%b", ctl, 8'b0); end
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    total++; if (flush_cnt !== 4'd1) begin bad++; $display("FAIL lu_flush_cnt got=%0d exp=1", flush_cnt); end
    @(negedge clk);
    drive(1, 7, 2, 7, 0, 0, 0, 0, 0);
    #1;
    total++; if (ctl !== 8'b1100_0100) begin bad++; $display("FAIL lu_rs2_ctl got=%b exp=%b", ctl, 8'b1100_0100); end
  endtask

  task automatic test_lu_x0();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (ctl !== 8'b0) begin bad++; $display("FAIL lu_x0_ctl got=%b exp=%b", ctl, 8'b0); end
    @(negedge clk);
    drive(1, 3, 4, 5, 0, 0, 0, 0, 0);
    #1;
    total++; if (ctl !== 8'b0) begin bad++; $display("FAIL lu_nomatch_ctl got=%b exp=%b", ctl, 8'b0); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL lu_x0_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_branch_lu();
    do_reset();
    drive(1, 5, 5, 1, 1, 0, 0, 0, 0);
    #1;
    total++; if (ctl !== 8'b0000_1100) begin bad++; $display("FAIL br_lu_ctl got=%b exp=%b", ctl, 8'b0000_1100); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (flush_cnt !== 4'd1) begin bad++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL br_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, i != 0, 0, 0, 1, 0);
      #1;
      total++; if (ctl !== 8'b1111_0001) begin bad++; $display("FAIL mem_wait_ctl[%0d] got=%b exp=%b", i, ctl, 8'b1111_0001); end
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    total++; if (ctl !== 8'b0) begin bad++; $display("FAIL mem_ready_ctl got=%b exp=%b", ctl, 8'b0); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (stall_cnt !== 4'd3) begin bad++; $display("FAIL mem_stall_cnt got=%0d exp=3", stall_cnt); end
    total++; if (flush_cnt !== 4'd0) begin bad++; $display("FAIL mem_flush_cnt got=%0d exp=0", flush_cnt); end
  endtask

  task automatic test_md_mem();
    logic [7:0] exp_ctl [10];
    exp_ctl = '{8'b1110_0010, 8'b1110_0010, 8'b1110_0010, 8'b1111_0001, 8'b1111_0001,
                8'b1111_0001, 8'b1111_0001, 8'b0, 8'b0, 8'b0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0, 0, 0, c <= 8, c == 5, c >= 3 && c <= 6, 0);
      #1;
      total++; if (ctl !== exp_ctl[c]) begin bad++; $display("FAIL md_mem_ctl[%0d] got=%b exp=%b", c, ctl, exp_ctl[c]); end
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (stall_cnt !== 4'd7) begin bad++; $display("FAIL md_stall_cnt got=%0d exp=7", stall_cnt); end
    total++; if (flush_cnt !== 4'd0) begin bad++; $display("FAIL md_flush_cnt got=%0d exp=0", flush_cnt); end
  endtask

  task automatic test_watchdog();
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int c = 0; c < 4; c++) @(negedge clk);
    #1;
    total++; if (md_timeout !== 1'b0) begin bad++; $display("FAIL wd_early got=%b exp=0", md_timeout); end
    @(negedge clk);
    #1;
    total++; if (md_timeout !== 1'b1) begin bad++; $display("FAIL wd_set got=%b exp=1", md_timeout); end
    total++; if (ctl !== 8'b1110_0010) begin bad++; $display("FAIL wd_still_wait got=%b exp=%b", ctl, 8'b1110_0010); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (ctl !== 8'b0000_1111) begin bad++; $display("FAIL wd_rst_ctl got=%b exp=%b", ctl, 8'b0000_1111); end
    total++; if (md_timeout !== 1'b0) begin bad++; $display("FAIL wd_rst_timeout got=%b exp=0", md_timeout); end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (ctl !== 8'b0) begin bad++; $display("FAIL wd_after_rst_ctl got=%b exp=%b", ctl, 8'b0); end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1, 9, 9, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) @(negedge clk);
    #1;
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_reach got=%0d exp=15", stall_cnt); end
    for (int i = 0; i < 4; i++) @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_stall_hold got=%0d exp=15", stall_cnt); end
    total++; if (flush_cnt !== 4'd15) begin bad++; $display("FAIL sat_flush_hold got=%0d exp=15", flush_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_lu_x0();
    test_branch_lu();
    test_mem_wait();
    test_md_mem();
    test_watchdog();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
